alu_share_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 21 ++
 rtl/alu_share_arbiter_alu.sv | 34 +++
 rtl/alu_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU opcodes, FSM state
// encoding and requester indices.
package alu_arb_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU datapath (the ALU32Bit block) used by the arbiter.
// Ports:
//   ctrl   - ALU operation code
//   a, b   - operands
//   result - operation result, modulo 2^WIDTH; unknown codes give 0
//   zero   - 1 when result == 0
module alu_share_arbiter_alu
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic [OPW-1:0]   ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (ctrl)
      OPW'(ALU_AND): result = a & b;
      OPW'(ALU_OR):  result = a | b;
      OPW'(ALU_ADD): result = a + b;
      OPW'(ALU_SUB): result = a - b;
      OPW'(ALU_SLT): result = (a < b) ? WIDTH'(1) : '0;
      OPW'(ALU_NOR): result = ~(a | b);
      default:       result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation
// in flight at a time. IDLE grants and latches operands, EXEC registers the
// ALU result, RESP holds it until the owning requester acknowledges.
// Ports:
//   Clk, Reset        - clock (rising edge), asynchronous active-high reset
//   req_valid/ready   - per-requester request handshake (ready is combinational)
//   req_ctrl/a/b      - packed per-requester op code and operands
//   rsp_valid/ready   - per-requester response handshake
//   rsp_result/zero   - shared result and zero flag, qualified by rsp_valid
//   busy              - high whenever the FSM is not IDLE
//   grant_cnt0/1, conflict_cnt - saturating perf counters, present only
//                       when ALU_ARB_PERF_EN is defined
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_ctrl,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]        grant_cnt0,
  output logic [31:0]        grant_cnt1,
  output logic [31:0]        conflict_cnt
`endif
);

  state_t           state;
  logic             prio;
  logic             owner;
  logic             grant;
  logic             accept;
  logic [OPW-1:0]   op_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   sel_ctrl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  // Grant selection: a lone requester wins outright, contention goes to prio.
  always_comb begin
    grant = prio;
    if (req_valid == 2'b01) grant = REQ0;
    else if (req_valid == 2'b10) grant = REQ1;
    accept    = (state == S_IDLE) && (req_valid != 2'b00) && !Reset;
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign sel_ctrl = grant ? req_ctrl[2*OPW-1:OPW]   : req_ctrl[OPW-1:0];
  assign sel_a    = grant ? req_a[2*WIDTH-1:WIDTH]  : req_a[WIDTH-1:0];
  assign sel_b    = grant ? req_b[2*WIDTH-1:WIDTH]  : req_b[WIDTH-1:0];

  alu_share_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .ctrl   (op_ctrl),
    .a      (op_a),
    .b      (op_b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      prio       <= REQ0;
      owner      <= REQ0;
      op_ctrl    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 2'b00;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_ctrl <= sel_ctrl;
            op_a    <= sel_a;
            op_b    <= sel_b;
            owner   <= grant;
            state   <= S_EXEC;
            busy    <= 1'b1;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
          state      <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's acknowledge completes; prio moves to the other side.
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            prio      <= ~owner;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Saturating grant and contention counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (accept && (grant == REQ0) && (grant_cnt0 != '1))
        grant_cnt0 <= grant_cnt0 + 32'd1;
      if (accept && (grant == REQ1) && (grant_cnt1 != '1))
        grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((state == S_IDLE) && (req_valid == 2'b11) && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;

  logic        Clk;
  logic        Reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] grant_cnt0;
  logic [31:0] grant_cnt1;
  logic [31:0] conflict_cnt;
`endif

  int tests;
  int fails;

  alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctrl[4*idx +: 4]   = c;
    req_a[32*idx +: 32]    = a;
    req_b[32*idx +: 32]    = b;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // Runs one uncontended operation; ok=0 if accept or response never came.
  task automatic run_op(input int idx, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output bit ok);
    bit acc;
    acc = 0;
    ok  = 0;
    r   = '0;
    z   = 1'b0;
    set_req(idx, c, a, b);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req_ready[idx]) begin acc = 1; break; end
      tick();
    end
    tick();
    req_valid[idx] = 1'b0;
    if (acc) begin
      for (int i = 0; i < 10; i++) begin
        if (rsp_valid[idx]) begin ok = 1; break; end
        tick();
      end
    end
    r = rsp_result;
    z = rsp_zero;
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req_valid = 2'b11;
    #2;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    tests++; if (rsp_result !== 32'h0) begin fails++; $display("FAIL reset_rsp_result got %h exp 0", rsp_result); end
    tests++; if (rsp_zero !== 1'b0) begin fails++; $display("FAIL reset_rsp_zero got %b exp 0", rsp_zero); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    req_valid = 2'b00;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_op();
    set_req(0, 4'b0010, 32'd5, 32'd7);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b exp 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b1 || req_ready !== 2'b00) begin
      fails++; $display("FAIL single_exec got valid=%b busy=%b ready=%b exp 00/1/00", rsp_valid, busy, req_ready); end
    tick();
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL single_rsp_valid got %b exp 01", rsp_valid); end
    tests++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
      fails++; $display("FAIL single_result got %h/%b exp 0000000c/0", rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'd12) begin
      fails++; $display("FAIL single_after got valid=%b busy=%b res=%h exp 00/0/0000000c", rsp_valid, busy, rsp_result); end
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 4'b0110, 32'd9, 32'd9);
    set_req(1, 4'b0001, 32'hF0, 32'h0F);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL cont_first_grant got %b exp 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL cont_exec_ready got %b exp 00", req_ready); end
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h0 || rsp_zero !== 1'b1) begin
      fails++; $display("FAIL cont_rsp0 got %b/%h/%b exp 01/0/1", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL cont_second_grant got %b exp 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin
      fails++; $display("FAIL cont_rsp1 got %b/%h/%b exp 10/ff/0", rsp_valid, rsp_result, rsp_zero); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    // prio is back on requester 0
    set_req(0, 4'b0010, 32'd1, 32'd2);
    set_req(1, 4'b0010, 32'd3, 32'd4);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL cont_repeat_grant got %b exp 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    rsp_ready = 2'b10;
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'd3) begin
      fails++; $display("FAIL cont_wrong_ack got %b/%h exp 01/00000003", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL cont_repeat_second got %b exp 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    tick();
    tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd7) begin
      fails++; $display("FAIL cont_repeat_rsp1 got %b/%h exp 10/00000007", rsp_valid, rsp_result); end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic        z;
    bit          ok;
    set_req(1, 4'b0111, 32'd3, 32'd4);
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_grant got %b exp 10", req_ready); end
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 4'b0000, 32'hF0F0, 32'hFF00);
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if (rsp_valid !== 2'b10 || rsp_result !== 32'd1 || req_ready !== 2'b00 || busy !== 1'b1) begin
        fails++; $display("FAIL bp_hold cyc=%0d got %b/%h/%b/%b exp 10/00000001/00/1", i, rsp_valid, rsp_result, req_ready, busy); end
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL bp_release got %b exp 00", rsp_valid); end
    req_valid[0] = 1'b0;
    run_op(0, 4'b0000, 32'hF0F0, 32'hFF00, r, z, ok);
    tests++; if (!ok || r !== 32'hF000 || z !== 1'b0) begin
      fails++; $display("FAIL bp_waiting_req0 got ok=%0d %h/%b exp 1 0000f000/0", ok, r, z); end
  endtask

  task automatic test_wrap_illegal();
    logic [3:0]  vc [6];
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    logic        vz [6];
    logic [31:0] r;
    logic        z;
    bit          ok;
    vc[0] = 4'b0010; va[0] = 32'hFFFFFFFF; vb[0] = 32'd1;        vr[0] = 32'h0;        vz[0] = 1'b1;
    vc[1] = 4'b1010; va[1] = 32'd5;        vb[1] = 32'd6;        vr[1] = 32'h0;        vz[1] = 1'b1;
    vc[2] = 4'b1100; va[2] = 32'h0;        vb[2] = 32'h0;        vr[2] = 32'hFFFFFFFF; vz[2] = 1'b0;
    vc[3] = 4'b0110; va[3] = 32'd3;        vb[3] = 32'd5;        vr[3] = 32'hFFFFFFFE; vz[3] = 1'b0;
    vc[4] = 4'b0111; va[4] = 32'd1;        vb[4] = 32'hFFFFFFFF; vr[4] = 32'd1;        vz[4] = 1'b0;
    vc[5] = 4'b0111; va[5] = 32'hFFFFFFFF; vb[5] = 32'd1;        vr[5] = 32'd0;        vz[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(0, vc[i], va[i], vb[i], r, z, ok);
      tests++; if (!ok || r !== vr[i] || z !== vz[i]) begin
        fails++; $display("FAIL wrap_vec%0d got ok=%0d %h/%b exp 1 %h/%b", i, ok, r, z, vr[i], vz[i]); end
    end
  endtask

  task automatic test_reset_exec();
    logic [31:0] r;
    logic        z;
    bit          ok;
    set_req(0, 4'b0010, 32'd1, 32'd1);
    tick();
    req_valid = 2'b00;
    Reset = 1'b1;
    #1;
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'h0) begin
      fails++; $display("FAIL rst_exec_out got %b/%b/%h exp 00/0/0", rsp_valid, busy, rsp_result); end
    tick();
    Reset = 1'b0;
    tick();
    tick();
    tests++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_exec_no_rsp got %b/%b exp 00/0", rsp_valid, busy); end
    set_req(0, 4'b0001, 32'h10, 32'h01);
    set_req(1, 4'b0010, 32'd20, 32'd22);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rst_exec_prio got %b exp 01", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    tests++; if (rsp_valid !== 2'b01 || rsp_result !== 32'h11) begin
      fails++; $display("FAIL rst_exec_serve got %b/%h exp 01/00000011", rsp_valid, rsp_result); end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req_valid[1] = 1'b0;
    run_op(1, 4'b0010, 32'd20, 32'd22, r, z, ok);
    tests++; if (!ok || r !== 32'd42) begin fails++; $display("FAIL rst_exec_req1 got ok=%0d %h exp 1 0000002a", ok, r); end
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    logic [31:0] r;
    logic        z;
    bit          ok;
    do_reset();
    tests++; if (grant_cnt0 !== 32'd0 || conflict_cnt !== 32'd0) begin
      fails++; $display("FAIL perf_reset got %0d/%0d exp 0/0", grant_cnt0, conflict_cnt); end
    set_req(0, 4'b0010, 32'd1, 32'd1);
    set_req(1, 4'b0010, 32'd2, 32'd2);
    tick();
    req_valid[0] = 1'b0;
    tick();
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req_valid[1] = 1'b0;
    run_op(1, 4'b0010, 32'd2, 32'd2, r, z, ok);
    run_op(0, 4'b0000, 32'd3, 32'd3, r, z, ok);
    run_op(0, 4'b0001, 32'd4, 32'd4, r, z, ok);
    run_op(1, 4'b0110, 32'd5, 32'd4, r, z, ok);
    tests++; if (grant_cnt0 !== 32'd3) begin fails++; $display("FAIL perf_grant0 got %0d exp 3", grant_cnt0); end
    tests++; if (grant_cnt1 !== 32'd2) begin fails++; $display("FAIL perf_grant1 got %0d exp 2", grant_cnt1); end
    tests++; if (conflict_cnt !== 32'd1) begin fails++; $display("FAIL perf_conflict got %0d exp 1", conflict_cnt); end
  endtask
`endif

  initial begin
    tests     = 0;
    fails     = 0;
    Reset     = 1'b0;
    req_valid = 2'b00;
    req_ctrl  = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    #2;
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_wrap_illegal();
    test_reset_exec();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
